wb_commit_checker: RTL and testbench

//  Sits directly downstream of the core writeback stage and consumes each retiring instruction:
//  - the commit PC;
//  - the register-file write port.

---
 rtl/wb_commit_if.sv | 50 +++++
 rtl/wb_commit_checker.sv | 186 ++++++++++++++++++
 tb/tb_wb_commit_checker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// ============================================================================
//  Module      : wb_commit_if
//  Description : Bundles the writeback commit port, the trace-FIFO read port
//                and the sticky status flags of wb_commit_checker.
//                master : the core/consumer side (drives commit_*, trace_rd)
//                slave  : the checker side (drives trace_*, status flags)
//  Ports       : commit_vld/pc/rf_wen/rf_waddr/rf_wdata  retiring instruction
//                trace_rd                                 trace pop request
//                trace_vld/pc/wen/waddr/wdata             popped trace entry
//                trace_empty, trace_ovf                   FIFO status
//                done, pass, fail, timeout_err            test verdict
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_commit_if;
    logic        commit_vld;
    logic [31:0] commit_pc;
    logic        commit_rf_wen;
    logic [4:0]  commit_rf_waddr;
    logic [31:0] commit_rf_wdata;
    logic        trace_rd;
    logic        trace_vld;
    logic [31:0] trace_pc;
    logic        trace_wen;
    logic [4:0]  trace_waddr;
    logic [31:0] trace_wdata;
    logic        trace_empty;
    logic        trace_ovf;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout_err;

    modport master (
        output commit_vld, commit_pc, commit_rf_wen, commit_rf_waddr, commit_rf_wdata,
        output trace_rd,
        input  trace_vld, trace_pc, trace_wen, trace_waddr, trace_wdata,
        input  trace_empty, trace_ovf, done, pass, fail, timeout_err
    );

    modport slave (
        input  commit_vld, commit_pc, commit_rf_wen, commit_rf_waddr, commit_rf_wdata,
        input  trace_rd,
        output trace_vld, trace_pc, trace_wen, trace_waddr, trace_wdata,
        output trace_empty, trace_ovf, done, pass, fail, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/wb_commit_checker.sv
// ============================================================================
//  Module      : wb_commit_checker
//  Description : Consumes every retiring instruction from the writeback
//                stage, records it in a commit-trace FIFO and shadows one
//                architectural register. When END_PC retires, the shadowed
//                value is compared with CHK_VAL and a sticky pass/fail is
//                raised. A commit-gap watchdog forces fail on a stall.
//  Ports       : clk     core clock
//                resetn  asynchronous active-low reset
//                bus     wb_commit_if.slave (commit port, trace port, flags)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_commit_checker #(
    parameter logic [31:0] END_PC  = 32'h1c000028,
    parameter int          CHK_REG = 5,
    parameter logic [31:0] CHK_VAL = 32'h5a,
    parameter int          DEPTH   = 8,
    parameter int          TIMEOUT = 4096
) (
    input  wire logic  clk,
    input  wire logic  resetn,
    wb_commit_if.slave bus
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = $clog2(TIMEOUT + 1);
    localparam int          EW         = 32 + 1 + 5 + 32;
    localparam logic [4:0]  C_CHK_ADDR = 5'(CHK_REG);
    localparam logic [CW-1:0] C_TMO_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_set_tmo;
    logic [CW-1:0]   r_tmo_cnt;
    logic [31:0]     r_shadow;
    logic            r_timeout_err;
    logic            r_ovf;
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [EW-1:0]   r_mem [DEPTH];
    logic            r_trace_vld;
    logic [EW-1:0]   r_trace_entry;

    logic            w_active;
    logic            w_wr_chk;
    logic [31:0]     w_chk_val;
    logic            w_end;
    logic            w_tmo_hit;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_drop;

    // Every commit_* use is qualified by commit_vld so that undriven
    // commit fields between retirements cannot leak into state.
    assign w_active   = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_wr_chk   = bus.commit_vld && bus.commit_rf_wen &&
                        (bus.commit_rf_waddr == C_CHK_ADDR) && (C_CHK_ADDR != 5'd0);
    // The END_PC instruction may itself write the checked register; its
    // data is not yet in the shadow, so forward it.
    assign w_chk_val  = w_wr_chk ? bus.commit_rf_wdata : r_shadow;
    assign w_end      = bus.commit_vld && (bus.commit_pc == END_PC);
    assign w_tmo_hit  = (r_tmo_cnt == C_TMO_MAX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.commit_vld) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_end) begin
                    w_state_nxt = (w_chk_val == CHK_VAL) ? S_PASS : S_FAIL;
                end else if (!bus.commit_vld && w_tmo_hit) begin
                    w_state_nxt = S_FAIL;
                    w_set_tmo   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // ------------------------------------------------ watchdog and shadow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
            r_shadow      <= '0;
        end else begin
            if (r_state == S_RUN) begin
                if (bus.commit_vld) begin
                    r_tmo_cnt <= '0;
                end else if (!w_tmo_hit) begin
                    r_tmo_cnt <= r_tmo_cnt + CW'(1);
                end
            end
            if (w_set_tmo) begin
                r_timeout_err <= 1'b1;
            end
            if (w_wr_chk) begin
                r_shadow <= bus.commit_rf_wdata;
            end
        end
    end

    // ---------------------------------------------------------- trace FIFO
    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop      = bus.trace_rd && !w_empty;
    assign w_push_req = bus.commit_vld && w_active;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Storage carries no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.commit_pc, bus.commit_rf_wen,
                                      bus.commit_rf_waddr, bus.commit_rf_wdata};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_ovf         <= 1'b0;
            r_trace_vld   <= 1'b0;
            r_trace_entry <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr        <= r_rptr + 1'b1;
                r_trace_entry <= r_mem[r_rptr[AW-1:0]];
            end
            r_trace_vld <= w_pop;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.trace_vld   = r_trace_vld;
    assign bus.trace_pc    = r_trace_entry[69:38];
    assign bus.trace_wen   = r_trace_entry[37];
    assign bus.trace_waddr = r_trace_entry[36:32];
    assign bus.trace_wdata = r_trace_entry[31:0];
    assign bus.trace_empty = w_empty;
    assign bus.trace_ovf   = r_ovf;
    assign bus.done        = (r_state == S_PASS) || (r_state == S_FAIL);
    assign bus.pass        = (r_state == S_PASS);
    assign bus.fail        = (r_state == S_FAIL);
    assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_checker.sv
// ============================================================================
//  Module      : tb_wb_commit_checker
//  Description : Self-checking bench for wb_commit_checker. Verdict scenarios
//                come from a record table; FIFO, watchdog and reset corners
//                are hand-written sequences. Trace entries are predicted in a
//                scoreboard queue when commits are driven and compared when
//                the checker presents them on the trace port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_checker;

    localparam logic [31:0] END_PC  = 32'h1c000028;
    localparam int          DEPTH   = 8;
    localparam int          TIMEOUT = 4096;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    wb_commit_if bus ();

    wb_commit_checker #(
        .END_PC  (END_PC),
        .CHK_REG (5),
        .CHK_VAL (32'h5a),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [69:0] exp_q[$];
    bit          m_term;
    bit          m_ovf;

    typedef struct {
        string       name;
        logic [31:0] pre_wd;
        logic        mid_wen;
        logic [4:0]  mid_wa;
        logic [31:0] mid_wd;
        logic        end_wen;
        logic [4:0]  end_wa;
        logic [31:0] end_wd;
        logic        exp_pass;
    } row_t;

    row_t rows[8];

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] flags();
        return {bus.done, bus.pass, bus.fail, bus.timeout_err,
                bus.trace_ovf, bus.trace_vld, bus.trace_empty};
    endfunction

    // One clock: inputs applied at the negedge, outputs checked at the next.
    task automatic cyc(input logic vld, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd, input logic rd);
        bit          nonempty;
        bit          full;
        logic [69:0] e;
        nonempty = (exp_q.size() != 0);
        full     = (exp_q.size() >= DEPTH);
        bus.commit_vld      = vld;
        bus.commit_pc       = pc;
        bus.commit_rf_wen   = wen;
        bus.commit_rf_waddr = wa;
        bus.commit_rf_wdata = wd;
        bus.trace_rd        = rd;
        if (vld && !m_term) begin
            if (!full || (rd && nonempty)) exp_q.push_back({pc, wen, wa, wd});
            else                           m_ovf = 1'b1;
            if (pc == END_PC) m_term = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.commit_vld      = 1'b0;
        bus.commit_pc       = 'x;
        bus.commit_rf_wen   = 'x;
        bus.commit_rf_waddr = 'x;
        bus.commit_rf_wdata = 'x;
        bus.trace_rd        = 1'b0;
        @(negedge clk);
        if (rd || bus.trace_vld) check("trace_vld", bus.trace_vld, rd && nonempty);
        if (rd && nonempty) begin
            e = exp_q.pop_front();
            check("trace_entry", {bus.trace_pc, bus.trace_wen, bus.trace_waddr, bus.trace_wdata}, e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && exp_q.size() != 0; k++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
        check("drain_empty", bus.trace_empty, 1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        m_term = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic run_row(input row_t r);
        do_reset();
        cyc(1'b1, 32'h1c000020, 1'b1, 5'd5, r.pre_wd, 1'b0);
        check({r.name, "_early"}, {bus.done, bus.pass, bus.fail}, 3'b000);
        if (r.mid_wen) cyc(1'b1, 32'h1c000024, 1'b1, r.mid_wa, r.mid_wd, 1'b0);
        cyc(1'b1, END_PC, r.end_wen, r.end_wa, r.end_wd, 1'b0);
        check({r.name, "_verdict"}, {bus.done, bus.pass, bus.fail, bus.timeout_err},
              {1'b1, r.exp_pass, !r.exp_pass, 1'b0});
        // Commits after the verdict change nothing and are not traced.
        cyc(1'b1, 32'h1c00002c, 1'b1, 5'd5, 32'h5a, 1'b0);
        check({r.name, "_sticky"}, {bus.done, bus.pass, bus.fail, bus.timeout_err},
              {1'b1, r.exp_pass, !r.exp_pass, 1'b0});
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rows[0] = '{"t1_pass",     32'h5a, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1};
        rows[1] = '{"t2_mismatch", 32'h33, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0};
        rows[2] = '{"t3_bypass",   32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h5a, 1'b1};
        rows[3] = '{"bypass_bad",  32'h5a, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11, 1'b0};
        rows[4] = '{"t3_r0",       32'h5a, 1'b1, 5'd0, 32'h33, 1'b0, 5'd0, 32'h0,  1'b1};
        rows[5] = '{"last_write",  32'h5a, 1'b1, 5'd5, 32'h77, 1'b0, 5'd0, 32'h0,  1'b0};
        rows[6] = '{"end_other",   32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h5a, 1'b0};
        rows[7] = '{"mid_other",   32'h5a, 1'b1, 5'd6, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1};

        bus.commit_vld      = 1'b0;
        bus.commit_pc       = '0;
        bus.commit_rf_wen   = 1'b0;
        bus.commit_rf_waddr = '0;
        bus.commit_rf_wdata = '0;
        bus.trace_rd        = 1'b0;
        m_term = 1'b0;
        m_ovf  = 1'b0;

        @(negedge clk);
        check("reset_flags", flags(), 7'b0000001);
        do_reset();
        check("reset_release", flags(), 7'b0000001);

        for (int i = 0; i < 8; i++) run_row(rows[i]);

        // Watchdog: one commit, then silence until the gap limit expires.
        do_reset();
        cyc(1'b1, 32'h1c000000, 1'b1, 5'd1, 32'h1, 1'b0);
        idle(TIMEOUT - 6);
        check("t4_not_early", bus.fail, 1'b0);
        for (int k = 0; k < 20 && !bus.fail; k++) idle(1);
        check("t4_timeout", {bus.done, bus.pass, bus.fail, bus.timeout_err}, 4'b1011);
        m_term = 1'b1;
        cyc(1'b1, END_PC, 1'b1, 5'd5, 32'h5a, 1'b0);
        check("t4_sticky", {bus.done, bus.pass, bus.fail, bus.timeout_err}, 4'b1011);
        drain();

        // Overflow: nine commits into eight slots, then drain in order.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h1c000000 + 32'(4 * i), 1'b0, 5'd0, 32'(i), 1'b0);
        check("t5_ovf", {bus.trace_ovf, bus.trace_empty}, {m_ovf, 1'b0});
        check("t5_ovf_abs", bus.trace_ovf, 1'b1);
        drain();
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);   // pop while empty
        check("t5_underflow", {bus.trace_empty, bus.trace_ovf}, 2'b11);

        // Full with simultaneous push and pop: both happen, no overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1c000100 + 32'(4 * i), 1'b1, 5'd2, 32'(i), 1'b0);
        cyc(1'b1, 32'h1c000200, 1'b1, 5'd3, 32'hbeef, 1'b1);
        check("t5_full_pushpop", bus.trace_ovf, 1'b0);
        drain();

        // Empty with simultaneous push and pop: pop ignored, entry kept.
        do_reset();
        cyc(1'b1, 32'h1c000300, 1'b1, 5'd4, 32'hcafe, 1'b1);
        check("empty_pushpop", bus.trace_empty, 1'b0);
        drain();

        // Asynchronous reset in the middle of a run.
        do_reset();
        cyc(1'b1, 32'h1c000000, 1'b1, 5'd5, 32'h1, 1'b0);
        cyc(1'b1, 32'h1c000004, 1'b1, 5'd5, 32'h2, 1'b0);
        cyc(1'b1, 32'h1c000008, 1'b1, 5'd5, 32'h3, 1'b1);
        resetn = 1'b0;
        #1;
        check("t6_async_reset", flags(), 7'b0000001);
        run_row(rows[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
